// File: rtl/rs_latch_ctrl_if.sv
// rs_latch_ctrl_if: request/ack handshake and latch drive/feedback bundle
interface rs_latch_ctrl_if;
  logic set_req;
  logic clr_req;
  logic err_clr;
  logic q;
  logic s_n;
  logic r_n;
  logic set_ack;
  logic clr_ack;
  logic busy;
  logic err;
  modport master (output set_req, clr_req, err_clr, q, input s_n, r_n, set_ack, clr_ack, busy, err);
  modport slave (input set_req, clr_req, err_clr, q, output s_n, r_n, set_ack, clr_ack, busy, err);
endinterface

// File: rtl/rs_latch_ctrl.sv
// rs_latch_ctrl: round-robin pulse driver for a NAND RS latch with settle and q check
module rs_latch_ctrl #(
  parameter int PULSE_W = 2,
  parameter int SETTLE_W = 1
) (
  input logic clk,
  input logic rst,
  rs_latch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;
  state_t state, nxt;
  logic [3:0] cnt, cnt_nxt;
  logic set_pend, clr_pend, last_set, cur_set, cur_set_nxt;
  logic grant, grant_set, mismatch;
  // next state: grant opposite of last_grant on contention, count pulse then settle, check once
  always_comb begin
    grant = state == IDLE && (set_pend || clr_pend);
    grant_set = set_pend && (!clr_pend || !last_set);
    nxt = state;
    cnt_nxt = cnt - 4'd1;
    cur_set_nxt = cur_set;
    if (state == IDLE) begin
      cnt_nxt = grant ? 4'(PULSE_W - 1) : cnt;
      nxt = grant ? PULSE : IDLE;
      cur_set_nxt = grant ? grant_set : cur_set;
    end else if (state == PULSE && cnt == 4'd0) begin
      nxt = SETTLE_W == 0 ? CHECK : SETTLE;
      cnt_nxt = 4'(SETTLE_W - 1);
    end else if (state == SETTLE && cnt == 4'd0) begin
      nxt = CHECK;
    end else if (state == CHECK) begin
      nxt = IDLE;
    end
    mismatch = nxt == CHECK && state != CHECK && bus.q != cur_set;
  end
  // state, pending flags and outputs registered from next state so drives never glitch both low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      cur_set <= 1'b0;
      last_set <= 1'b0;
      set_pend <= 1'b0;
      clr_pend <= 1'b0;
      bus.s_n <= 1'b1;
      bus.r_n <= 1'b1;
      bus.set_ack <= 1'b0;
      bus.clr_ack <= 1'b0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      cur_set <= cur_set_nxt;
      if (grant) last_set <= grant_set;
      set_pend <= bus.set_req | (set_pend & ~(grant & grant_set));
      clr_pend <= bus.clr_req | (clr_pend & ~(grant & ~grant_set));
      bus.s_n <= !(nxt == PULSE && cur_set_nxt);
      bus.r_n <= !(nxt == PULSE && !cur_set_nxt);
      bus.set_ack <= nxt == CHECK && cur_set_nxt;
      bus.clr_ack <= nxt == CHECK && !cur_set_nxt;
      bus.busy <= nxt != IDLE;
      bus.err <= mismatch | (bus.err & ~bus.err_clr);
    end
  end
endmodule

// File: tb/tb_rs_latch_ctrl.sv
// tb_rs_latch_ctrl: directed cycle-trace checks of rs_latch_ctrl against NAND latch models
module tb_rs_latch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stuck = 1'b0;
  logic qa_lat = 1'b0;
  logic qb_lat = 1'b0;
  int tests = 0;
  int fails = 0;
  int both_low = 0;
  logic [31:0] sl_a, rl_a, sa_a, ca_a, bz_a, er_a, rl_b, ca_b;
  rs_latch_ctrl_if a();
  rs_latch_ctrl_if b();
  rs_latch_ctrl dut (.clk(clk), .rst(rst), .bus(a));
  rs_latch_ctrl #(.PULSE_W(1), .SETTLE_W(0)) dut_b (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  // NAND RS latch behaviour: low set forces 1, low reset forces 0, else hold
  always @(a.s_n, a.r_n) if (!a.s_n) qa_lat = 1'b1; else if (!a.r_n) qa_lat = 1'b0;
  always @(b.s_n, b.r_n) if (!b.s_n) qb_lat = 1'b1; else if (!b.r_n) qb_lat = 1'b0;
  assign a.q = stuck ? 1'b0 : qa_lat;
  assign b.q = qb_lat;
  // forbidden both-low drive watch
  always @(negedge clk) if ((!a.s_n && !a.r_n) || (!b.s_n && !b.r_n)) both_low++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [31:0] sr, input logic [31:0] cr, input logic [31:0] ec, input int n);
    {sl_a, rl_a, sa_a, ca_a, bz_a, er_a, rl_b, ca_b} = '0;
    for (int c = 0; c < n; c++) begin
      a.set_req = sr[c];
      a.clr_req = cr[c];
      a.err_clr = ec[c];
      b.set_req = sr[c];
      b.clr_req = cr[c];
      @(negedge clk);
      sl_a[c] = ~a.s_n;
      rl_a[c] = ~a.r_n;
      sa_a[c] = a.set_ack;
      ca_a[c] = a.clr_ack;
      bz_a[c] = a.busy;
      er_a[c] = a.err;
      rl_b[c] = ~b.r_n;
      ca_b[c] = b.clr_ack;
      @(posedge clk);
      #1;
    end
    {a.set_req, a.clr_req, a.err_clr, b.set_req, b.clr_req} = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    {a.set_req, a.clr_req, a.err_clr, b.set_req, b.clr_req, b.err_clr} = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_s_n", 32'(a.s_n), 32'd1);
    check("rst_r_n", 32'(a.r_n), 32'd1);
    check("rst_busy", 32'(a.busy), 32'd0);
    check("rst_acks", 32'({a.set_ack, a.clr_ack}), 32'd0);
    check("rst_err", 32'(a.err), 32'd0);
    run(32'h1, 32'h0, 32'h0, 8);
    check("single_s_low", sl_a, 32'h0C);
    check("single_r_low", rl_a, 32'h00);
    check("single_set_ack", sa_a, 32'h20);
    check("single_busy", bz_a, 32'h3C);
    check("single_err", er_a, 32'h00);
    check("single_q", 32'(a.q), 32'd1);
    do_reset();
    run(32'h1, 32'h1, 32'h0, 12);
    check("both_s_low", sl_a, 32'h0C);
    check("both_set_ack", sa_a, 32'h20);
    check("both_r_low", rl_a, 32'h180);
    check("both_clr_ack", ca_a, 32'h400);
    check("both_busy", bz_a, 32'h7BC);
    check("both_q", 32'(a.q), 32'd0);
    run(32'h7, 32'h0, 32'h0, 16);
    check("merge_set_ack", sa_a, 32'h420);
    check("merge_s_low", sl_a, 32'h18C);
    check("merge_clr_ack", ca_a, 32'h0);
    do_reset();
    stuck = 1'b1;
    run(32'h1, 32'h0, 32'h0, 8);
    check("stuck_set_ack", sa_a, 32'h20);
    check("stuck_err", er_a, 32'hE0);
    check("stuck_err_hold", 32'(a.err), 32'd1);
    a.err_clr = 1'b1;
    @(posedge clk);
    #1 a.err_clr = 1'b0;
    check("err_clr", 32'(a.err), 32'd0);
    run(32'h1, 32'h0, 32'h10, 8);
    check("err_set_wins", er_a, 32'hE0);
    stuck = 1'b0;
    a.err_clr = 1'b1;
    @(posedge clk);
    #1 a.err_clr = 1'b0;
    do_reset();
    run(32'h1, 32'h0, 32'h0, 3);
    #2 check("midrst_pre", 32'(a.s_n), 32'd0);
    rst = 1'b1;
    #1 check("midrst_async_s_n", 32'(a.s_n), 32'd1);
    check("midrst_busy", 32'(a.busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run(32'h0, 32'h0, 32'h0, 8);
    check("midrst_no_ack", sa_a | ca_a, 32'h0);
    run(32'h1, 32'h0, 32'h0, 8);
    check("midrst_fresh_s_low", sl_a, 32'h0C);
    check("midrst_fresh_ack", sa_a, 32'h20);
    do_reset();
    run(32'h0, 32'h1, 32'h0, 6);
    check("short_r_low", rl_b, 32'h4);
    check("short_clr_ack", ca_b, 32'h8);
    check("never_both_low", 32'(both_low), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rs_latch_ctrl.md
# rs_latch_ctrl

Clocked controller that drives the active-low set/reset inputs of a NAND RS latch on behalf of two requesters (a set requester and a clear requester). It captures request pulses, arbitrates round-robin when both are pending, generates a fixed-width active-low pulse on exactly one latch input, waits a settle interval, then checks the latch output against the expected value and acknowledges. The block sits between synchronous control logic and an asynchronous RS latch, and guarantees the latch never sees the forbidden both-low input combination.

## Interface
- PULSE_W, 2, cycles the active-low drive is held low; legal 1..15
- SETTLE_W, 1, idle cycles between pulse end and q check; legal 0..15 (0 skips SETTLE)

- clk_in  input  1  system clock, rising edge
- rst_in  input  1  reset, asynchronous, active-high
- set_req_in  input  1  single-cycle set request pulse
- clr_req_in  input  1  single-cycle clear request pulse
- err_clr_in  input  1  synchronous clear of err_out
- q_in  input  1  latch q feedback
- s_n_out  output  1  to latch set input, active-low
- r_n_out  output  1  to latch reset input, active-low
- set_ack_out  output  1  one-cycle pulse: set operation complete
- clr_ack_out  output  1  one-cycle pulse: clear operation complete
- busy_out  output  1  high in any state other than IDLE
- err_out  output  1  sticky: q_in mismatched expected value at a check

## Operation
- Pending flags set_pend, clr_pend: set by the corresponding req pulse, cleared when granted. A req pulse in the same cycle as its grant leaves the flag set (set wins). Repeated pulses while pending merge into one operation.
- last_grant register (SET/CLR) drives round-robin; reset value CLR, so the first contended grant goes to SET.
- States: IDLE, PULSE, SETTLE, CHECK.
  - IDLE: if exactly one flag pending, grant it; if both, grant the type opposite last_grant. On grant: cur_op <= granted type, last_grant <= granted type, counter <= PULSE_W-1, go PULSE. No pending -> stay.
  - PULSE: drive low the input for cur_op (SET -> s_n_out=0, CLR -> r_n_out=0); the other stays 1. Counter decrements; at 0 go SETTLE (counter <= SETTLE_W-1) or, if SETTLE_W=0, go CHECK.
  - SETTLE: both drives 1; counter decrements; at 0 go CHECK.
  - CHECK: both drives 1; assert ack for cur_op; expected q = 1 for SET, 0 for CLR; mismatch sets err_out. Next state IDLE unconditionally.
- Outputs s_n_out, r_n_out, acks and busy_out are registered (decoded from next state), glitch-free.
- Invariant: s_n_out and r_n_out are never both 0 in any cycle, including reset.
- err_out: set by mismatch, cleared by err_clr_in; mismatch in same cycle as err_clr_in wins (err stays 1).

## Timing
- Reset (async, immediate): s_n_out=1, r_n_out=1, set_ack_out=0, clr_ack_out=0, busy_out=0, err_out=0, state IDLE, pending flags 0, last_grant CLR. Reset mid-PULSE releases the latch drive immediately; interrupted op is dropped with no ack.
- Latency, req pulse in cycle 0: pending visible cycle 1; PULSE cycles 2..PULSE_W+1; SETTLE next SETTLE_W cycles; CHECK/ack in cycle PULSE_W+SETTLE_W+2. Defaults: ack in cycle 5, IDLE in cycle 6.
- Back-to-back: a pending op is granted in the first IDLE cycle after CHECK; one IDLE cycle separates operations (minimum both-high gap = SETTLE_W+2 cycles).
- Simultaneous set_req_in and clr_req_in in IDLE-reachable cycle: both captured; served in round-robin order, never merged or dropped.
- Requests arriving while busy are held pending, never lost.

## Test plan
- Reset then single set_req_in pulse at cycle 0, latch model attached, defaults -> s_n_out=0 in cycles 2-3, set_ack_out=1 in cycle 5 only, q_in=1, err_out=0.
- Simultaneous set/clr pulses after reset -> SET served first (ack cycle 5), CLR granted cycle 7, r_n_out=0 cycles 7-8, clr_ack_out in cycle 10; no cycle with both drives low.
- Two set pulses 1 cycle apart plus a set pulse during grant cycle -> exactly two set operations performed, two set_ack_out pulses.
- Latch model forced stuck at 0, set request -> set_ack_out still pulses, err_out rises at ack cycle and stays; err_clr_in pulse -> err_out 0 next cycle.
- rst_in asserted in cycle 3 of a set op -> s_n_out returns to 1 without waiting for clock; no ack; next request behaves as from fresh reset.
- PULSE_W=1, SETTLE_W=0 build, clr request cycle 0 -> r_n_out=0 cycle 2 only, clr_ack_out cycle 3.
